// File: rtl/rbz_spi_reg_master.sv
// SPI mode-0 transmitter for the raybox_zero register/vector inputs.
// One {cmd, payload} word per valid/ready handshake, shifted out MSB first.
module rbz_spi_reg_master #(
   parameter int unsigned CMD_W     = 4,
   parameter int unsigned PAYLOAD_W = 24,
   parameter int unsigned SCLK_HALF = 2,
   parameter int unsigned CSB_GAP   = 2
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic                           i_valid,
   output logic                           o_ready,
   input  logic [CMD_W-1:0]               i_cmd,
   input  logic [PAYLOAD_W-1:0]           i_data,
   input  logic [$clog2(PAYLOAD_W+1)-1:0] i_len,
   output logic                           o_busy,
   output logic                           o_done,
   output logic                           o_csb,
   output logic                           o_sclk,
   output logic                           o_mosi
);

   localparam int unsigned LEN_W   = $clog2(PAYLOAD_W + 1);
   localparam int unsigned SH_W    = CMD_W + PAYLOAD_W;
   localparam int unsigned BITS_W  = $clog2(SH_W + 1);
   localparam int unsigned CNT_MAX = (SCLK_HALF > CSB_GAP) ? SCLK_HALF : CSB_GAP;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(SCLK_HALF - 1);
   localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(CSB_GAP - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOW,
      HIGH,
      HOLD,
      GAP
   } state_t;

   state_t              state;
   logic [SH_W-1:0]     shreg;
   logic [BITS_W-1:0]   bits;
   logic [CNT_W-1:0]    cnt;

   logic [LEN_W-1:0]     leff_c;
   logic [LEN_W-1:0]     shamt_c;
   logic [PAYLOAD_W-1:0] payload_c;
   logic [SH_W-1:0]      frame_c;
   logic [BITS_W-1:0]    nbits_c;

   // Clamp the length and left-align the payload; bits above Leff shift out.
   always_comb begin
      leff_c    = (i_len > LEN_W'(PAYLOAD_W)) ? LEN_W'(PAYLOAD_W) : i_len;
      shamt_c   = LEN_W'(PAYLOAD_W) - leff_c;
      payload_c = i_data << shamt_c;
      frame_c   = {i_cmd, payload_c};
      nbits_c   = BITS_W'(CMD_W) + BITS_W'(leff_c);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state   <= IDLE;
         shreg   <= '0;
         bits    <= '0;
         cnt     <= '0;
         o_ready <= 1'b1;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         o_csb   <= 1'b1;
         o_sclk  <= 1'b0;
         o_mosi  <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_valid) begin
                  shreg   <= frame_c;
                  bits    <= nbits_c;
                  cnt     <= HALF_LD;
                  o_csb   <= 1'b0;
                  o_mosi  <= frame_c[SH_W-1];
                  o_ready <= 1'b0;
                  o_busy  <= 1'b1;
                  state   <= LOW;
               end
            end
            LOW: begin
               if (cnt == '0) begin
                  cnt    <= HALF_LD;
                  o_sclk <= 1'b1;
                  state  <= HIGH;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HIGH: begin
               if (cnt == '0) begin
                  cnt    <= HALF_LD;
                  o_sclk <= 1'b0;
                  // Next bit goes out on the same edge SCLK falls.
                  if (bits > BITS_W'(1)) begin
                     bits   <= bits - 1'b1;
                     shreg  <= shreg << 1;
                     o_mosi <= shreg[SH_W-2];
                     state  <= LOW;
                  end else begin
                     state <= HOLD;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  cnt    <= GAP_LD;
                  o_csb  <= 1'b1;
                  o_mosi <= 1'b0;
                  state  <= GAP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            GAP: begin
               if (cnt == '0) begin
                  o_done  <= 1'b1;
                  o_ready <= 1'b1;
                  o_busy  <= 1'b0;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               o_ready <= 1'b1;
               o_busy  <= 1'b0;
               o_csb   <= 1'b1;
               o_sclk  <= 1'b0;
               o_mosi  <= 1'b0;
            end
         endcase
      end
   end

endmodule
